sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares one external single-port SRAM between the CPU core's instruction-fetch port (rom_*) and data port (ram_*).
- Sits between cpu_path and the board memory controller.
- Serialises the two requests, with data taking priority because it belongs to the older instruction.
- Raises a stall request to the pipeline control until every requested access in the current cycle group has completed. Latched read data is presented in the release cycle.

Parameters:
- ADDR_W, 32, address width of both CPU ports and the SRAM port
- DATA_W, 32, data width
- TIMEOUT, 255, maximum SRAM wait cycles before an access is force-completed; counter width is clog2(TIMEOUT+1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- rom_ce_i  in  1  fetch request
- rom_addr_i  in  ADDR_W  fetch address
- rom_data_o  out  DATA_W  fetched instruction, valid when stallreq_o=0 and the state is DONE
- ram_ce_i  in  1  data request
- ram_we_i  in  1  1 = store
- ram_sel_i  in  4  byte enables
- ram_addr_i  in  ADDR_W  data address
- ram_wdata_i  in  DATA_W  store data
- ram_rdata_o  out  DATA_W  load data, valid as for rom_data_o
- flush_i  in  1  pipeline flush from ctrl
- stallreq_o  out  1  stall request to ctrl
- bus_err_o  out  1  one-cycle pulse when an access times out
- sram_req_o  out  1  SRAM request, held until ack
- sram_we_o  out  1  write enable
- sram_sel_o  out  4  byte enables
- sram_addr_o  out  ADDR_W  address
- sram_wdata_o  out  DATA_W  write data
- sram_rdata_i  in  DATA_W  read data, valid with ack
- sram_ack_i  in  1  access complete, single-cycle

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0; rom/ram data latches 0; abort_q=0; timeout counter 0.
- States: IDLE, DACC, IACC, DONE. Encoding is 2-bit.
- IDLE:
  - stallreq_o = rom_ce_i | ram_ce_i, combinational, so the pipeline stalls in the same cycle.
  - If ram_ce_i: go to DACC. Else if rom_ce_i: go to IACC. Else stay in IDLE.
- DACC:
  - Drive sram_req_o=1, sram_we_o=ram_we_i, and sel/addr/wdata from the ram_* inputs.
  - stallreq_o=1.
  - On sram_ack_i: ram_rdata latch <= sram_rdata_i (loads only; stores leave the latch unchanged). Then go to IACC if rom_ce_i, else DONE.
- IACC:
  - Drive sram_req_o=1, sram_we_o=0, sram_sel_o=4'b1111, sram_addr_o=rom_addr_i.
  - stallreq_o=1.
  - On ack: rom_data latch <= sram_rdata_i, then go to DONE.
- DONE:
  - stallreq_o=0, sram_req_o=0.
  - rom_data_o and ram_rdata_o present the latched values.
  - Unconditionally go to IDLE. Requests seen in IDLE on the following cycle are treated as new.
- rom_data_o and ram_rdata_o are registered and hold their value outside DONE.
- sram_* outputs are 0 whenever sram_req_o=0.
- Latency with zero-wait SRAM (ack in the first request cycle):
  - Single access: IDLE, ACC, DONE = 3 cycles.
  - Both ports: 4 cycles.
  - Each SRAM wait cycle adds 1.
- Timeout:
  - The counter clears on entry to DACC/IACC and increments each cycle without ack.
  - When it reaches TIMEOUT: treat as ack with read data 0 and pulse bus_err_o for one cycle.
  - The SRAM side must still see sram_req_o drop.
- Flush:
  - flush_i in IDLE or DONE: next state is IDLE; stallreq_o=0 in that cycle.
  - flush_i in DACC/IACC: set abort_q. The in-flight beat must complete, because the request is never withdrawn mid-beat. On ack or timeout go to IDLE, skipping any pending IACC and DONE, and clear abort_q.
  - While abort_q=1, stallreq_o=0.
- Simultaneous ack and flush_i: the access completes, its latch updates, and the next state is IDLE.
- Request inputs are sampled every cycle; the core holds them stable while stalled. No buffering beyond one access per port.

Decomposition:
- Shared package holds:
  - state encodings (ARB_IDLE=2'd0, ARB_DACC=2'd1, ARB_IACC=2'd2, ARB_DONE=2'd3);
  - the default TIMEOUT;
  - SRAM sel constant SEL_WORD=4'b1111.
- One sub-module: sram_watchdog (timeout counter with clear/enable inputs and an expired output).

Test Plan:
- Fetch only: rom_ce_i=1, addr=0x100, SRAM acks next cycle with 0x3C010001 -> stallreq_o high 2 cycles; in DONE rom_data_o=0x3C010001; sram_we_o=0 throughout.
- Load and fetch together: ram addr=0x200 returns 0xDEADBEEF, rom addr=0x104 returns 0x24420004, zero wait -> DACC before IACC; stallreq_o high 3 cycles; in DONE both outputs correct.
- Store with sel=4'b0011, wdata=0x0000ABCD, 2 wait states -> sram_we_o=1, sel/wdata stable for 3 cycles until ack; ram_rdata_o unchanged.
- Timeout with TIMEOUT=4 and ack never asserted -> after 4 wait cycles bus_err_o pulses once; ram_rdata_o=0 in DONE; sram_req_o drops.
- Flush during DACC with a pending fetch -> request held until ack; next state IDLE; IACC never entered; stallreq_o low from the flush cycle.
- Assert rst low mid-IACC -> all outputs 0 immediately without a clock edge; state IDLE after release.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter shared types and constants.
// State encodings, default timeout, word select.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_DACC = 2'd1,
    ARB_IACC = 2'd2,
    ARB_DONE = 2'd3
  } arb_state_t;

  localparam int TIMEOUT_DEF = 255;

  localparam logic [3:0] SEL_WORD = 4'b1111;

endpackage

// File: rtl/sram_watchdog.sv
// Wait-cycle counter for one SRAM beat.
// expired is high once TIMEOUT cycles pass without ack.
module sram_watchdog
  import sram_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW =
    (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  assign expired = (cnt == CW'(TIMEOUT));

  // count wait cycles, restart per beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Fetch/data arbiter for one single-port SRAM.
// Data beat first, then fetch, then a release cycle.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce_i,
  input  logic [ADDR_W-1:0] rom_addr_i,
  output logic [DATA_W-1:0] rom_data_o,
  input  logic              ram_ce_i,
  input  logic              ram_we_i,
  input  logic [3:0]        ram_sel_i,
  input  logic [ADDR_W-1:0] ram_addr_i,
  input  logic [DATA_W-1:0] ram_wdata_i,
  output logic [DATA_W-1:0] ram_rdata_o,
  input  logic              flush_i,
  output logic              stallreq_o,
  output logic              bus_err_o,
  output logic              sram_req_o,
  output logic              sram_we_o,
  output logic [3:0]        sram_sel_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [DATA_W-1:0] sram_wdata_o,
  input  logic [DATA_W-1:0] sram_rdata_i,
  input  logic              sram_ack_i
);

  arb_state_t        state;
  arb_state_t        state_n;
  logic              abort_q;
  logic              abort_n;
  logic [DATA_W-1:0] rom_q;
  logic [DATA_W-1:0] ram_q;
  logic              acc;
  logic              fin;
  logic              kill;
  logic              expired;

  assign acc  = (state == ARB_DACC)
             || (state == ARB_IACC);
  assign fin  = acc && (sram_ack_i || expired);
  assign kill = abort_q || flush_i;

  assign rom_data_o  = rom_q;
  assign ram_rdata_o = ram_q;

  sram_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (!acc || fin),
    .en      (acc && !sram_ack_i),
    .expired (expired)
  );

  // state, abort flag and read-data latches
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ARB_IDLE;
      abort_q <= 1'b0;
      rom_q   <= '0;
      ram_q   <= '0;
    end else begin
      state   <= state_n;
      abort_q <= abort_n;
      if (fin && state == ARB_DACC && !ram_we_i)
        ram_q <= sram_ack_i ? sram_rdata_i : '0;
      if (fin && state == ARB_IACC)
        rom_q <= sram_ack_i ? sram_rdata_i : '0;
    end
  end

  // next state; a flushed beat still runs to ack
  always_comb begin
    state_n = state;
    abort_n = abort_q;
    unique case (state)
      ARB_IDLE: begin
        abort_n = 1'b0;
        if (flush_i)       state_n = ARB_IDLE;
        else if (ram_ce_i) state_n = ARB_DACC;
        else if (rom_ce_i) state_n = ARB_IACC;
      end
      ARB_DACC: begin
        if (fin) begin
          abort_n = 1'b0;
          if (kill)          state_n = ARB_IDLE;
          else if (rom_ce_i) state_n = ARB_IACC;
          else               state_n = ARB_DONE;
        end else if (flush_i) begin
          abort_n = 1'b1;
        end
      end
      ARB_IACC: begin
        if (fin) begin
          abort_n = 1'b0;
          state_n = kill ? ARB_IDLE : ARB_DONE;
        end else if (flush_i) begin
          abort_n = 1'b1;
        end
      end
      ARB_DONE: state_n = ARB_IDLE;
    endcase
  end

  // SRAM drive, stall and timeout pulse
  always_comb begin
    stallreq_o   = 1'b0;
    bus_err_o    = 1'b0;
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_sel_o   = '0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    unique case (state)
      ARB_IDLE: begin
        stallreq_o = rst && !flush_i
                  && (rom_ce_i || ram_ce_i);
      end
      ARB_DACC: begin
        sram_req_o   = 1'b1;
        sram_we_o    = ram_we_i;
        sram_sel_o   = ram_sel_i;
        sram_addr_o  = ram_addr_i;
        sram_wdata_o = ram_wdata_i;
        stallreq_o   = !kill;
        bus_err_o    = expired && !sram_ack_i;
      end
      ARB_IACC: begin
        sram_req_o  = 1'b1;
        sram_sel_o  = SEL_WORD;
        sram_addr_o = rom_addr_i;
        stallreq_o  = !kill;
        bus_err_o   = expired && !sram_ack_i;
      end
      ARB_DONE: begin
        stallreq_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomised bench for sram_arbiter.
// Queue-of-beats model plus literal anchors.
module tb_sram_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          rom_ce_i;
  logic [AW-1:0] rom_addr_i;
  logic [DW-1:0] rom_data_o;
  logic          ram_ce_i;
  logic          ram_we_i;
  logic [3:0]    ram_sel_i;
  logic [AW-1:0] ram_addr_i;
  logic [DW-1:0] ram_wdata_i;
  logic [DW-1:0] ram_rdata_o;
  logic          flush_i;
  logic          stallreq_o;
  logic          bus_err_o;
  logic          sram_req_o;
  logic          sram_we_o;
  logic [3:0]    sram_sel_o;
  logic [AW-1:0] sram_addr_o;
  logic [DW-1:0] sram_wdata_o;
  logic [DW-1:0] sram_rdata_i;
  logic          sram_ack_i;

  always #5 clk = ~clk;

  sram_arbiter #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rom_ce_i     (rom_ce_i),
    .rom_addr_i   (rom_addr_i),
    .rom_data_o   (rom_data_o),
    .ram_ce_i     (ram_ce_i),
    .ram_we_i     (ram_we_i),
    .ram_sel_i    (ram_sel_i),
    .ram_addr_i   (ram_addr_i),
    .ram_wdata_i  (ram_wdata_i),
    .ram_rdata_o  (ram_rdata_o),
    .flush_i      (flush_i),
    .stallreq_o   (stallreq_o),
    .bus_err_o    (bus_err_o),
    .sram_req_o   (sram_req_o),
    .sram_we_o    (sram_we_o),
    .sram_sel_o   (sram_sel_o),
    .sram_addr_o  (sram_addr_o),
    .sram_wdata_o (sram_wdata_o),
    .sram_rdata_i (sram_rdata_i),
    .sram_ack_i   (sram_ack_i)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // model: 1 = data beat, 2 = fetch beat, 3 = release
  int          beats[$];
  int          w;
  int          tgt;
  bit          abort_m;
  logic [31:0] m_rom;
  logic [31:0] m_ram;
  int          tq[$];
  logic [31:0] dq[$];

  int          st_cnt;
  int          err_cnt;
  bit          saw_i;
  logic [31:0] done_rom;
  logic [31:0] done_ram;

  task automatic chk(string nm,
                     logic [63:0] act,
                     logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic pick();
    if (tq.size() != 0) tgt = tq.pop_front();
    else tgt = $urandom_range(0, 5);
  endtask

  task automatic model_reset();
    beats.delete();
    w = 0;
    tgt = 0;
    abort_m = 0;
    m_rom = '0;
    m_ram = '0;
  endtask

  // one clock: drive SRAM side, compare, advance
  task automatic step();
    int          head;
    bit          ack;
    bit          tmo;
    logic [31:0] rd;
    bit          e_st;
    bit          e_req;
    bit          e_we;
    bit          e_err;
    logic [3:0]  e_sel;
    logic [31:0] e_ad;
    logic [31:0] e_wd;
    head = (beats.size() != 0) ? beats[0] : 0;
    ack  = (head == 1 || head == 2) && (w == tgt);
    rd   = $urandom();
    if (ack && dq.size() != 0) rd = dq.pop_front();
    sram_ack_i   = ack;
    sram_rdata_i = rd;
    #1;
    tmo   = (head == 1 || head == 2)
         && !ack && (w == TO);
    e_st  = 0; e_req = 0; e_we = 0; e_err = 0;
    e_sel = '0; e_ad = '0; e_wd = '0;
    if (head == 0) begin
      e_st = (rom_ce_i || ram_ce_i) && !flush_i;
    end else if (head == 1) begin
      e_req = 1; e_we = ram_we_i;
      e_sel = ram_sel_i; e_ad = ram_addr_i;
      e_wd  = ram_wdata_i;
      e_st  = !(abort_m || flush_i);
      e_err = tmo;
    end else if (head == 2) begin
      e_req = 1; e_sel = 4'hF;
      e_ad  = rom_addr_i;
      e_st  = !(abort_m || flush_i);
      e_err = tmo;
    end
    chk("stallreq", stallreq_o, e_st);
    chk("bus_err", bus_err_o, e_err);
    chk("sram_req", sram_req_o, e_req);
    chk("sram_we", sram_we_o, e_we);
    chk("sram_sel", sram_sel_o, e_sel);
    chk("sram_addr", sram_addr_o, e_ad);
    chk("sram_wdata", sram_wdata_o, e_wd);
    chk("rom_data", rom_data_o, m_rom);
    chk("ram_rdata", ram_rdata_o, m_ram);
    if (stallreq_o) st_cnt++;
    if (bus_err_o) err_cnt++;
    if (head == 2) saw_i = 1;
    if (head == 3) begin
      done_rom = rom_data_o;
      done_ram = ram_rdata_o;
    end
    @(posedge clk);
    if (head == 0) begin
      if (!flush_i && (rom_ce_i || ram_ce_i)) begin
        if (ram_ce_i) beats.push_back(1);
        if (rom_ce_i) beats.push_back(2);
        beats.push_back(3);
        w = 0;
        pick();
      end
    end else if (head == 3) begin
      void'(beats.pop_front());
    end else if (ack || tmo) begin
      if (head == 1 && !ram_we_i)
        m_ram = ack ? rd : 32'h0;
      if (head == 2)
        m_rom = ack ? rd : 32'h0;
      void'(beats.pop_front());
      if (abort_m || flush_i) begin
        beats.delete();
        abort_m = 0;
      end else begin
        w = 0;
        if (beats[0] != 3) pick();
      end
    end else begin
      w++;
      if (flush_i) abort_m = 1;
    end
    @(negedge clk);
  endtask

  task automatic drain(int maxc);
    int c = 0;
    while (beats.size() != 0 && c < maxc) begin
      step();
      c++;
    end
    if (beats.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_bound: got busy want idle");
      beats.delete();
    end
  endtask

  task automatic txn();
    st_cnt = 0;
    err_cnt = 0;
    saw_i = 0;
    step();
    drain(40);
    rom_ce_i = 0;
    ram_ce_i = 0;
  endtask

  initial begin
    rst = 1; flush_i = 0;
    rom_ce_i = 1; ram_ce_i = 1;
    rom_addr_i = '0; ram_we_i = 0;
    ram_sel_i = '0; ram_addr_i = '0;
    ram_wdata_i = '0; sram_ack_i = 0;
    sram_rdata_i = '0;
    model_reset();
    #2 rst = 0;
    #1;
    chk("rst_stall", stallreq_o, 0);
    chk("rst_req", sram_req_o, 0);
    chk("rst_rom", rom_data_o, 0);
    chk("rst_ram", ram_rdata_o, 0);
    rom_ce_i = 0; ram_ce_i = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    step();

    rom_ce_i = 1; rom_addr_i = 32'h100;
    tq = '{0}; dq = '{32'h3C010001};
    txn();
    chk("fetch_stall_cycles", st_cnt, 2);
    chk("fetch_data", done_rom, 32'h3C010001);

    ram_ce_i = 1; ram_we_i = 0;
    ram_addr_i = 32'h200; ram_sel_i = 4'hF;
    rom_ce_i = 1; rom_addr_i = 32'h104;
    tq = '{0, 0};
    dq = '{32'hDEADBEEF, 32'h24420004};
    txn();
    chk("both_stall_cycles", st_cnt, 3);
    chk("both_ram", done_ram, 32'hDEADBEEF);
    chk("both_rom", done_rom, 32'h24420004);

    ram_ce_i = 1; ram_we_i = 1;
    ram_sel_i = 4'b0011;
    ram_wdata_i = 32'h0000ABCD;
    tq = '{2};
    txn();
    chk("store_stall_cycles", st_cnt, 4);
    chk("store_keeps_ram", done_ram, 32'hDEADBEEF);

    ram_ce_i = 1; ram_we_i = 0;
    tq = '{5};
    txn();
    chk("tmo_err_pulses", err_cnt, 1);
    chk("tmo_ram_zero", done_ram, 0);
    chk("tmo_stall_cycles", st_cnt, 6);

    ram_ce_i = 1; ram_we_i = 0;
    rom_ce_i = 1;
    tq = '{2}; dq = '{32'h11223344};
    st_cnt = 0; saw_i = 0;
    step();
    step();
    flush_i = 1;
    step();
    flush_i = 0;
    step();
    chk("flush_idle", beats.size(), 0);
    chk("flush_no_iacc", saw_i, 0);
    chk("flush_stall_cycles", st_cnt, 2);
    chk("flush_ram", ram_rdata_o, 32'h11223344);
    rom_ce_i = 0; ram_ce_i = 0;
    step();

    tq.delete(); dq.delete();
    for (int i = 0; i < 3000; i++) begin
      if (beats.size() == 0) begin
        rom_ce_i    = ($urandom_range(0, 2) != 0);
        ram_ce_i    = ($urandom_range(0, 2) != 0);
        ram_we_i    = $urandom_range(0, 1);
        ram_sel_i   = $urandom();
        ram_addr_i  = $urandom();
        rom_addr_i  = $urandom();
        ram_wdata_i = $urandom();
      end
      flush_i = ($urandom_range(0, 7) == 0);
      step();
    end
    flush_i = 0;
    drain(40);

    rom_ce_i = 1; ram_ce_i = 0;
    rom_addr_i = 32'h300;
    m_ram = ram_rdata_o;
    tq = '{5};
    step();
    step();
    #2 rst = 0;
    #1;
    chk("mrst_stall", stallreq_o, 0);
    chk("mrst_req", sram_req_o, 0);
    chk("mrst_addr", sram_addr_o, 0);
    chk("mrst_sel", sram_sel_o, 0);
    chk("mrst_err", bus_err_o, 0);
    chk("mrst_rom", rom_data_o, 0);
    chk("mrst_ram", ram_rdata_o, 0);
    model_reset();
    tq.delete();
    @(negedge clk);
    rst = 1;
    rom_ce_i = 0;
    repeat (3) step();
    rom_ce_i = 1;
    rom_addr_i = 32'h304;
    tq = '{1};
    dq = '{32'h0BADF00D};
    txn();
    chk("post_rst_fetch", done_rom, 32'h0BADF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
